// File: rtl/sub_result_analyzer.sv
// Checker for a WIDTH-bit ripple subtractor (a + ~b + bin): samples operands and outputs,
// compares against a golden model, counts tests/mismatches and latches the first failing vector.
module sub_result_analyzer #(
    parameter int WIDTH     = 4,
    parameter int NUM_TESTS = 512,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_bin,
    input  logic [WIDTH-1:0] dut_result,
    input  logic             dut_cout,
    input  logic             dut_ovf,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] test_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_bin
);
    // state  | meaning
    // IDLE   | waiting for start after reset
    // RUN    | capturing and comparing vectors
    // DONE   | NUM_TESTS compares finished, results held
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ALL  = CNT_W'(NUM_TESTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TESTS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] tc_q, tc_d;
    logic [CNT_W-1:0] ec_q, ec_d;
    logic             fev_q, fev_d;
    logic [WIDTH-1:0] fea_q, fea_d;
    logic [WIDTH-1:0] feb_q, feb_d;
    logic             febin_q, febin_d;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_bin_q, s1_bin_d;
    logic [WIDTH-1:0] s1_res_q, s1_res_d;
    logic             s1_cout_q, s1_cout_d;
    logic             s1_ovf_q, s1_ovf_d;

    logic [WIDTH:0]   gold;
    logic [WIDTH-1:0] gold_low;
    logic             exp_ovf;
    logic             mismatch;
    logic             accept;
    logic             compare;

    // gold_low is the sum below the MSB; its top bit is the carry into the MSB.
    assign gold     = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{WIDTH{1'b0}}, s1_bin_q};
    assign gold_low = {1'b0, s1_a_q[WIDTH-2:0]} + {1'b0, ~s1_b_q[WIDTH-2:0]}
                    + {{(WIDTH-1){1'b0}}, s1_bin_q};
    assign exp_ovf  = gold_low[WIDTH-1] ^ gold[WIDTH];
    assign mismatch = (gold[WIDTH-1:0] != s1_res_q) || (gold[WIDTH] != s1_cout_q)
                   || (exp_ovf != s1_ovf_q);

    assign accept  = (state_q == S_RUN) && in_valid && (acc_q != CNT_ALL);
    assign compare = (state_q == S_RUN) && s1_valid_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        tc_d       = tc_q;
        ec_d       = ec_q;
        fev_d      = fev_q;
        fea_d      = fea_q;
        feb_d      = feb_q;
        febin_d    = febin_q;
        s1_valid_d = accept;
        s1_a_d     = accept ? op_a       : s1_a_q;
        s1_b_d     = accept ? op_b       : s1_b_q;
        s1_bin_d   = accept ? op_bin     : s1_bin_q;
        s1_res_d   = accept ? dut_result : s1_res_q;
        s1_cout_d  = accept ? dut_cout   : s1_cout_q;
        s1_ovf_d   = accept ? dut_ovf    : s1_ovf_q;
        case (state_q)
            S_RUN: begin
                if (accept) acc_d = acc_q + CNT_ONE;
                if (compare) begin
                    tc_d = tc_q + CNT_ONE;
                    if (mismatch) begin
                        if (ec_q != {CNT_W{1'b1}}) ec_d = ec_q + CNT_ONE;
                        if (!fev_q) begin
                            fev_d   = 1'b1;
                            fea_d   = s1_a_q;
                            feb_d   = s1_b_q;
                            febin_d = s1_bin_q;
                        end
                    end
                    if (tc_q == CNT_LAST) state_d = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    tc_d    = '0;
                    ec_d    = '0;
                    fev_d   = 1'b0;
                    fea_d   = '0;
                    feb_d   = '0;
                    febin_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            tc_q       <= '0;
            ec_q       <= '0;
            fev_q      <= 1'b0;
            fea_q      <= '0;
            feb_q      <= '0;
            febin_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_bin_q   <= 1'b0;
            s1_res_q   <= '0;
            s1_cout_q  <= 1'b0;
            s1_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tc_q       <= tc_d;
            ec_q       <= ec_d;
            fev_q      <= fev_d;
            fea_q      <= fea_d;
            feb_q      <= feb_d;
            febin_q    <= febin_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_bin_q   <= s1_bin_d;
            s1_res_q   <= s1_res_d;
            s1_cout_q  <= s1_cout_d;
            s1_ovf_q   <= s1_ovf_d;
        end
    end

    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign pass            = (state_q == S_DONE) && (ec_q == '0);
    assign test_count      = tc_q;
    assign err_count       = ec_q;
    assign first_err_valid = fev_q;
    assign first_err_a     = fea_q;
    assign first_err_b     = feb_q;
    assign first_err_bin   = febin_q;
endmodule

// File: tb/tb_sub_result_analyzer.sv
// Bench for sub_result_analyzer: directed spec vectors, full sweeps (clean and stuck-at),
// randomized vectors with injected faults, and mid-run reset.
module tb_sub_result_analyzer;
    localparam int N = 512;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, op_bin, dut_cout, dut_ovf;
    logic [3:0] op_a, op_b, dut_result;
    logic       busy, done, pass, first_err_valid, first_err_bin;
    logic [9:0] test_count, err_count;
    logic [3:0] first_err_a, first_err_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sub_result_analyzer #(.WIDTH(4), .NUM_TESTS(N), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .op_a(op_a), .op_b(op_b), .op_bin(op_bin),
        .dut_result(dut_result), .dut_cout(dut_cout), .dut_ovf(dut_ovf),
        .busy(busy), .done(done), .pass(pass),
        .test_count(test_count), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_a(first_err_a),
        .first_err_b(first_err_b), .first_err_bin(first_err_bin)
    );

    wire [32:0] obs_all = {busy, done, pass, test_count, err_count,
                           first_err_valid, first_err_a, first_err_b, first_err_bin};

    // Reference subtractor from plain integer arithmetic: {result, cout, ovf}.
    function automatic logic [5:0] golden(input int a, input int b, input int bin);
        int s, sa, sb, sv;
        logic [3:0] r;
        logic c, v;
        s  = a + (15 - b) + bin;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        sv = sa - sb - 1 + bin;
        r  = 4'(s % 16);
        c  = (s >= 16);
        v  = (sv > 7) || (sv < -8);
        return {r, c, v};
    endfunction

    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic bn, input logic [5:0] outs, input logic st);
        in_valid   = v;
        op_a       = a;
        op_b       = b;
        op_bin     = bn;
        dut_result = outs[5:2];
        dut_cout   = outs[1];
        dut_ovf    = outs[0];
        start      = st;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        step(1'b0, 4'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic pulse_start();
        step(1'b0, 4'd0, 4'd0, 1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (obs_all !== 33'd0) begin
            fails++;
            $display("FAIL reset_state: got %h expected 0", obs_all);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        pulse_start();
        tests++;
        if (busy !== 1'b1 || test_count !== 10'd0) begin
            fails++;
            $display("FAIL start_to_run: busy=%b tc=%0d expected busy=1 tc=0", busy, test_count);
        end
        step(1'b1, 4'd5, 4'd3, 1'b1, {4'd2, 1'b1, 1'b0}, 1'b0);
        tests++;
        if (test_count !== 10'd0) begin
            fails++;
            $display("FAIL latency_one_edge: tc=%0d expected 0", test_count);
        end
        idle_cycle();
        tests++;
        if (test_count !== 10'd1 || err_count !== 10'd0) begin
            fails++;
            $display("FAIL basic_match: tc=%0d ec=%0d expected 1 0", test_count, err_count);
        end
        step(1'b1, 4'd8, 4'd1, 1'b1, {4'd7, 1'b1, 1'b1}, 1'b0);
        idle_cycle();
        tests++;
        if (test_count !== 10'd2 || err_count !== 10'd0) begin
            fails++;
            $display("FAIL ovf_match: tc=%0d ec=%0d expected 2 0", test_count, err_count);
        end
        step(1'b1, 4'd8, 4'd1, 1'b1, {4'd7, 1'b1, 1'b0}, 1'b0);
        idle_cycle();
        tests++;
        if ({err_count, first_err_valid, first_err_a, first_err_b, first_err_bin}
            !== {10'd1, 1'b1, 4'd8, 4'd1, 1'b1}) begin
            fails++;
            $display("FAIL ovf_mismatch: ec=%0d fev=%b fe=(%0d,%0d,%0d) expected 1 1 (8,1,1)",
                     err_count, first_err_valid, first_err_a, first_err_b, first_err_bin);
        end
        step(1'b1, 4'd0, 4'd1, 1'b1, {4'd15, 1'b0, 1'b0}, 1'b0);
        idle_cycle();
        tests++;
        if ({test_count, err_count, first_err_a} !== {10'd4, 10'd1, 4'd8}) begin
            fails++;
            $display("FAIL borrow_match: tc=%0d ec=%0d fea=%0d expected 4 1 8",
                     test_count, err_count, first_err_a);
        end
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
    endtask

    // Exhaustive sweep; stuck0 forces result bit0 low.
    task automatic test_sweep(input logic stuck0);
        int errs = 0;
        logic fev = 1'b0;
        logic [3:0] fa = 4'd0, fb = 4'd0;
        logic fbin = 1'b0;
        logic [5:0] g, o;
        logic [32:0] exp_all;
        pulse_start();
        for (int i = 0; i < N; i++) begin
            g = golden(i / 32, (i / 2) % 16, i % 2);
            o = g;
            if (stuck0) o[2] = 1'b0;
            if (o != g) begin
                errs++;
                if (!fev) begin
                    fev = 1'b1; fa = 4'(i / 32); fb = 4'((i / 2) % 16); fbin = 1'(i % 2);
                end
            end
            step(1'b1, 4'(i / 32), 4'((i / 2) % 16), 1'(i % 2), o, 1'b0);
        end
        idle_cycle();
        exp_all = {1'b0, 1'b1, (errs == 0), 10'(N), 10'(errs), fev, fa, fb, fbin};
        tests++;
        if (obs_all !== exp_all) begin
            fails++;
            $display("FAIL sweep_stuck%0d: got %h expected %h", stuck0, obs_all, exp_all);
        end
    endtask

    task automatic test_random();
        int acc = 0, errs = 0;
        logic fev = 1'b0;
        logic [3:0] fa = 4'd0, fb = 4'd0, a, b;
        logic fbin = 1'b0, bn, st;
        logic [5:0] g, o;
        logic [32:0] exp_all;
        pulse_start();
        while (acc < N) begin
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            bn = 1'($urandom_range(0, 1));
            g  = golden(int'(a), int'(b), int'(bn));
            o  = g;
            if ($urandom_range(0, 7) == 0) o = g ^ (6'd1 << $urandom_range(0, 5));
            st = (acc == 200);
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, a, b, bn, o ^ 6'h3f, st);
            end else begin
                if (o != g) begin
                    errs++;
                    if (!fev) begin fev = 1'b1; fa = a; fb = b; fbin = bn; end
                end
                step(1'b1, a, b, bn, o, st);
                acc++;
            end
        end
        for (int k = 0; k < 4; k++) step(1'b1, 4'd3, 4'd3, 1'b1, 6'h3f, 1'b0);
        exp_all = {1'b0, 1'b1, (errs == 0), 10'(N), 10'(errs), fev, fa, fb, fbin};
        tests++;
        if (obs_all !== exp_all) begin
            fails++;
            $display("FAIL random_run: got %h expected %h", obs_all, exp_all);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] g;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            g = golden(i / 32, (i / 2) % 16, i % 2);
            step(1'b1, 4'(i / 32), 4'((i / 2) % 16), 1'(i % 2), g, 1'b0);
        end
        idle_cycle();
        tests++;
        if (test_count !== 10'd100 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_run_count: tc=%0d busy=%b expected 100 1", test_count, busy);
        end
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        tests++;
        if (obs_all !== 33'd0) begin
            fails++;
            $display("FAIL mid_run_reset: got %h expected 0", obs_all);
        end
        pulse_start();
        g = golden(9, 12, 0);
        step(1'b1, 4'd9, 4'd12, 1'b0, g, 1'b0);
        idle_cycle();
        tests++;
        if ({busy, test_count, err_count} !== {1'b1, 10'd1, 10'd0}) begin
            fails++;
            $display("FAIL restart_after_reset: busy=%b tc=%0d ec=%0d expected 1 1 0",
                     busy, test_count, err_count);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        op_a = 4'd0; op_b = 4'd0; op_bin = 1'b0;
        dut_result = 4'd0; dut_cout = 1'b0; dut_ovf = 1'b0;
        test_reset();
        test_directed();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
